// File: rtl/morse_round_ctrl.sv
// Round controller for the Morse trainer: fetches the expected symbol from ROM,
// opens a timed answer window, scores the player's symbol and sequences the game.
module morse_round_ctrl #(
    parameter int unsigned ROUNDS        = 8,
    parameter int unsigned TIMEOUT_TICKS = 50,
    parameter int unsigned ADDR_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tick_100ms,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    input  logic              player_valid,
    input  logic [3:0]        player_sym,
    output logic              busy,
    output logic              armed,
    output logic              hit,
    output logic              miss,
    output logic              timeout,
    output logic [ADDR_W:0]   score,
    output logic              game_over
);

    localparam int unsigned SCORE_W = ADDR_W + 1;
    localparam int unsigned TICK_W  = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ARMED = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(ROUNDS - 1);
    localparam logic [TICK_W-1:0]  LAST_TICK = TICK_W'(TIMEOUT_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [2:0]         state, state_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [TICK_W-1:0]  tick_cnt, tick_nxt;
    logic [3:0]         expected, expected_nxt;
    logic [3:0]         sym_q, sym_nxt;
    logic               over_nxt, hit_nxt, miss_nxt, timeout_nxt, busy_nxt, armed_nxt;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            score     <= '0;
            tick_cnt  <= '0;
            expected  <= '0;
            sym_q     <= '0;
            game_over <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            score     <= score_nxt;
            tick_cnt  <= tick_nxt;
            expected  <= expected_nxt;
            sym_q     <= sym_nxt;
            game_over <= over_nxt;
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
            armed     <= armed_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        addr_nxt     = rom_addr;
        score_nxt    = score;
        tick_nxt     = tick_cnt;
        expected_nxt = expected;
        sym_nxt      = sym_q;
        over_nxt     = game_over;
        hit_nxt      = 1'b0;
        miss_nxt     = 1'b0;
        timeout_nxt  = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_nxt  = '0;
                    score_nxt = '0;
                    over_nxt  = 1'b0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                expected_nxt = rom_data;
                tick_nxt     = '0;
                state_nxt    = S_ARMED;
            end
            S_ARMED: begin
                if (tick_100ms) begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                end
                // A player answer beats an expiring tick in the same cycle
                if (player_valid) begin
                    sym_nxt   = player_sym;
                    state_nxt = S_CHECK;
                end else if (tick_100ms && (tick_cnt == LAST_TICK)) begin
                    timeout_nxt = 1'b1;
                    miss_nxt    = 1'b1;
                    state_nxt   = S_NEXT;
                end
            end
            S_CHECK: begin
                if (sym_q == expected) begin
                    hit_nxt = 1'b1;
                    if (score != SCORE_MAX) begin
                        score_nxt = score + SCORE_W'(1);
                    end
                end else begin
                    miss_nxt = 1'b1;
                end
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (rom_addr == LAST_ADDR) begin
                    over_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    addr_nxt  = rom_addr + ADDR_W'(1);
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt  = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        armed_nxt = (state_nxt == S_ARMED);
    end

endmodule

// File: doc/morse_round_ctrl.md
MORSE_ROUND_CTRL -- requirements
Module: morse_round_ctrl

Interface
REQ-001 SHALL provide parameter ROUNDS, default 8, number of symbols (ROM entries) per game, 1..2**ADDR_W.
REQ-002 SHALL provide parameter TIMEOUT_TICKS, default 50, number of 100 ms ticks allowed per round (5 s), range 1..255.
REQ-003 SHALL provide parameter ADDR_W, default 4, ROM address width.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a game.
REQ-007 tick_100ms  input  1  one-cycle pulse every 100 ms from the prescaler.
REQ-008 rom_addr  output  ADDR_W  address to the symbol ROM.
REQ-009 rom_data  input  4  expected symbol from the ROM, valid 1 cycle after rom_addr changes.
REQ-010 player_valid  input  1  one-cycle strobe, decoded player symbol present.
REQ-011 player_sym  input  4  player symbol, sampled only with player_valid.
REQ-012 busy  output  1  high in every state except IDLE and DONE.
REQ-013 armed  output  1  high while waiting for player input (ARMED).
REQ-014 hit  output  1  one-cycle pulse, round answered correctly.
REQ-015 miss  output  1  one-cycle pulse, round answered wrongly or timed out.
REQ-016 timeout  output  1  one-cycle pulse, round window expired, coincident with miss.
REQ-017 score  output  ADDR_W+1  count of hits in current game.
REQ-018 game_over  output  1  level, high in DONE.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, LOAD, ARMED, CHECK, NEXT, DONE.
REQ-020 IDLE/DONE + start: rom_addr<=0, score<=0, game_over<=0, -> FETCH; start SHALL be ignored in all other states.
REQ-021 FETCH: hold rom_addr one cycle, -> LOAD.
REQ-022 LOAD: latch rom_data into internal expected register, clear tick counter, -> ARMED.
REQ-023 ARMED: each tick_100ms pulse increments the 8-bit tick counter by 1.
REQ-024 ARMED + player_valid: latch player_sym, -> CHECK.
REQ-025 ARMED, no player_valid, tick_100ms arriving with counter == TIMEOUT_TICKS-1: assert timeout and miss next cycle, -> NEXT.
REQ-026 player_valid and the expiring tick in the same cycle: player input SHALL win; no timeout pulse.
REQ-027 CHECK: player_sym == expected -> hit pulse, score+1; else miss pulse; -> NEXT; hit/miss/timeout asserted for exactly one cycle.
REQ-028 score SHALL saturate at 2**(ADDR_W+1)-1, never wrap.
REQ-029 NEXT: rom_addr == ROUNDS-1 -> DONE, game_over<=1; else rom_addr+1, -> FETCH.
REQ-030 player_valid outside ARMED and tick_100ms outside ARMED SHALL be ignored, no state change.
REQ-031 DONE: score and rom_addr held until next start or reset.
REQ-032 Round latency: player_valid in ARMED -> hit/miss 2 cycles later; end of round -> next ARMED 4 cycles later (CHECK, NEXT, FETCH, LOAD).

Reset
REQ-033 rst low at a clock edge SHALL force IDLE, rom_addr=0, score=0, tick counter=0, expected=0, busy=0, armed=0, hit=0, miss=0, timeout=0, game_over=0, from any state including mid-round.
REQ-034 rst SHALL take priority over start, tick_100ms and player_valid in the same cycle.

Verification
REQ-035 ROUNDS=3, ROM {1,2,3}, start, answer 1,2,3 each 3 ticks into the window -> three hit pulses, score=3, game_over=1, miss never asserted.
REQ-036 TIMEOUT_TICKS=50, no player input -> timeout+miss pulse together on the cycle after the 50th tick, score unchanged, rom_addr advances by 1.
REQ-037 player_valid with wrong symbol (ROM 2, player 5) -> miss pulse 2 cycles later, no timeout, score unchanged.
REQ-038 player_valid coincident with 50th tick, correct symbol -> hit, no timeout.
REQ-039 rst low during ARMED of round 2 -> next cycle IDLE, score=0, rom_addr=0, all pulses low; subsequent start restarts at rom_addr 0.
REQ-040 start, tick_100ms and player_valid pulsed while in DONE/IDLE (not start) or mid-round (start) -> no state, score or address change.
